// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and types for the issue/decode hazard tracking logic.
package pipeline_pkg;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 2;

    typedef logic [4:0]       reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam cnt_t     CNT_MAX  = '1;
endpackage

// File: rtl/scoreboard_entry.sv
// One architectural register's in-flight writer count and long-latency flag.
module scoreboard_entry
    import pipeline_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic flush_dec,
    input  logic set_long,
    input  logic clr_long,
    output logic pending,
    output logic long_o,
    output logic ovf,
    output logic unf
);
    cnt_t       cnt_q, cnt_d;
    logic       long_q, long_d;
    logic [1:0] down, net;

    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        unf   = 1'b0;
        net   = 2'd0;
        // A WB retirement and a flushed EX writer can both hit this register in one cycle.
        down  = {1'b0, dec} + {1'b0, flush_dec};
        if (inc && (down == 2'd0)) begin
            if (cnt_q == CNT_MAX) begin
                ovf = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if ({1'b0, inc} < down) begin
            net = down - {1'b0, inc};
            if (cnt_q < cnt_t'(net)) begin
                cnt_d = '0;
                unf   = 1'b1;
            end else begin
                cnt_d = cnt_q - cnt_t'(net);
            end
        end

        // A new long writer outranks retirement of an older one.
        if (set_long) begin
            long_d = 1'b1;
        end else if (clr_long) begin
            long_d = 1'b0;
        end else begin
            long_d = long_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            long_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            long_q <= long_d;
        end
    end

    assign pending = (cnt_q != '0);
    assign long_o  = long_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers from issue to write-back and stalls decode
// on hazards the EX/MEM forwarding paths cannot cover.
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic                issue_regwrite,
    input  logic [4:0]          issue_rd,
    input  logic                issue_is_load,
    input  logic                issue_is_long,
    input  logic                flush_ex,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic                wb_long,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic                err
);
    logic                iss_go, iss, flush_hit;
    logic                ex_valid_q, ex_valid_d;
    logic                ex_load_q, ex_load_d;
    logic                ex_long_q, ex_long_d;
    reg_idx_t            ex_rd_q, ex_rd_d;
    logic                err_q, err_d;
    logic                stall_rs1, stall_rs2;
    logic [NUM_REGS-1:0] long_vec, ovf_vec, unf_vec;

    assign iss_go    = issue_valid && !stall;
    assign iss       = iss_go && issue_regwrite && (issue_rd != REG_ZERO);
    assign flush_hit = flush_ex && ex_valid_q;

    assign pending[0]  = 1'b0;
    assign long_vec[0] = 1'b0;
    assign ovf_vec[0]  = 1'b0;
    assign unf_vec[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        localparam reg_idx_t IDX = reg_idx_t'(r);
        scoreboard_entry u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (iss && (issue_rd == IDX)),
            .dec       (wb_valid && (wb_rd == IDX)),
            .flush_dec (flush_hit && (ex_rd_q == IDX)),
            .set_long  (iss && issue_is_long && (issue_rd == IDX)),
            .clr_long  ((wb_valid && wb_long && (wb_rd == IDX)) ||
                        (flush_hit && ex_long_q && (ex_rd_q == IDX))),
            .pending   (pending[r]),
            .long_o    (long_vec[r]),
            .ovf       (ovf_vec[r]),
            .unf       (unf_vec[r])
        );
    end

    // A long result being written back this cycle reaches ID through RF write-through.
    always_comb begin
        stall_rs1 = id_use_rs1 && (id_rs1 != REG_ZERO) &&
                    ((ex_valid_q && ex_load_q && (ex_rd_q == id_rs1)) ||
                     (long_vec[id_rs1] && !(wb_valid && wb_long && (wb_rd == id_rs1))));
        stall_rs2 = id_use_rs2 && (id_rs2 != REG_ZERO) &&
                    ((ex_valid_q && ex_load_q && (ex_rd_q == id_rs2)) ||
                     (long_vec[id_rs2] && !(wb_valid && wb_long && (wb_rd == id_rs2))));
        stall     = stall_rs1 || stall_rs2;
    end

    always_comb begin
        ex_valid_d = iss;
        ex_rd_d    = iss_go ? issue_rd : REG_ZERO;
        ex_load_d  = iss_go && issue_is_load;
        ex_long_d  = iss_go && issue_is_long;
        err_d      = err_q || (|ovf_vec) || (|unf_vec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rd_q    <= REG_ZERO;
            ex_load_q  <= 1'b0;
            ex_long_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            ex_load_q  <= ex_load_d;
            ex_long_q  <= ex_long_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a per-register counting model.
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_regwrite, issue_is_load, issue_is_long;
    logic [4:0]  issue_rd;
    logic        flush_ex, wb_valid, wb_long;
    logic [4:0]  wb_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic        stall, err;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    int         cnt_m [32];
    bit         long_m[32];
    bit         exv_m, exl_m, exlg_m, err_m;
    logic [4:0] exrd_m;
    bit         exp_stall;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_regwrite(issue_regwrite), .issue_rd(issue_rd),
        .issue_is_load(issue_is_load), .issue_is_long(issue_is_long),
        .flush_ex(flush_ex), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_long(wb_long),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .stall(stall), .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            cnt_m[r]  = 0;
            long_m[r] = 1'b0;
        end
        exv_m = 0; exl_m = 0; exlg_m = 0; err_m = 0; exrd_m = '0;
    endtask

    function automatic bit src_blocked(input logic [4:0] s, input logic u);
        if (!u || s == 5'd0) return 1'b0;
        if (exv_m && exl_m && exrd_m == s) return 1'b1;
        return long_m[s] && !(wb_valid && wb_long && wb_rd == s);
    endfunction

    task automatic model_update();
        bit go, is, fl;
        int c;
        go = issue_valid && !exp_stall;
        is = go && issue_regwrite && issue_rd != 5'd0;
        fl = flush_ex && exv_m;
        for (int r = 1; r < 32; r++) begin
            c = cnt_m[r];
            if (is && issue_rd == r) c = c + 1;
            if (wb_valid && wb_rd == r) c = c - 1;
            if (fl && exrd_m == r) c = c - 1;
            if (c > 3) begin c = 3; err_m = 1; end
            if (c < 0) begin c = 0; err_m = 1; end
            cnt_m[r] = c;
            if (is && issue_is_long && issue_rd == r) long_m[r] = 1'b1;
            else if ((wb_valid && wb_long && wb_rd == r) || (fl && exlg_m && exrd_m == r))
                long_m[r] = 1'b0;
        end
        exv_m  = is;
        exrd_m = go ? issue_rd : 5'd0;
        exl_m  = go && issue_is_load;
        exlg_m = go && issue_is_long;
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic settle();
        logic [31:0] ep;
        #1;
        exp_stall = src_blocked(id_rs1, id_use_rs1) || src_blocked(id_rs2, id_use_rs2);
        ep = '0;
        for (int r = 1; r < 32; r++) ep[r] = (cnt_m[r] != 0);
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("pending", pending, ep);
        chk("err", {31'd0, err}, {31'd0, err_m});
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        adv();
    endtask

    task automatic idle();
        issue_valid = 0; issue_regwrite = 0; issue_rd = 0; issue_is_load = 0; issue_is_long = 0;
        flush_ex = 0; wb_valid = 0; wb_rd = 0; wb_long = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld, input logic lg);
        issue_valid = 1; issue_regwrite = 1; issue_rd = rd; issue_is_load = ld; issue_is_long = lg;
    endtask

    task automatic id(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub);
        id_rs1 = a; id_use_rs1 = ua; id_rs2 = b; id_use_rs2 = ub;
    endtask

    task automatic wb(input logic [4:0] rd, input logic lg);
        wb_valid = 1; wb_rd = rd; wb_long = lg;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Load-use: exactly one bubble.
        issue(5, 1, 0); cycle();
        idle(); id(5, 1, 1, 1); issue(6, 0, 0);
        settle(); chk("lu_stall", {31'd0, stall}, 32'd1); adv();
        settle(); chk("lu_release", {31'd0, stall}, 32'd0); adv();
        idle(); settle(); chk("lu_pend5", {31'd0, pending[5]}, 32'd1); adv();
        wb(5, 0); cycle();
        idle(); settle();
        chk("lu_pend5_clr", {31'd0, pending[5]}, 32'd0);
        chk("lu_pend6", {31'd0, pending[6]}, 32'd1); adv();
        wb(6, 0); cycle(); idle();

        // Back-to-back writers to x7.
        issue(7, 0, 0); cycle();
        issue(7, 0, 0); id(7, 1, 0, 0);
        settle(); chk("b2b_nostall", {31'd0, stall}, 32'd0); adv();
        idle(); settle(); chk("b2b_pend", {31'd0, pending[7]}, 32'd1); adv();
        wb(7, 0); cycle();
        idle(); settle(); chk("b2b_pend_one", {31'd0, pending[7]}, 32'd1); adv();
        wb(7, 0); cycle();
        idle(); settle(); chk("b2b_pend_zero", {31'd0, pending[7]}, 32'd0); adv();

        // Long op with a dependent waiting in ID.
        issue(9, 0, 1); cycle();
        idle(); id(9, 1, 2, 1); issue(10, 0, 0);
        for (int i = 0; i < 3; i++) begin
            settle(); chk("long_stall", {31'd0, stall}, 32'd1); adv();
        end
        wb(9, 1);
        settle(); chk("long_wb_nostall", {31'd0, stall}, 32'd0); adv();
        idle(); id(9, 1, 0, 0);
        settle();
        chk("long_clr", {31'd0, stall}, 32'd0);
        chk("long_pend9", {31'd0, pending[9]}, 32'd0); adv();
        idle(); wb(10, 0); cycle();

        // Flush of a long op in EX, plus a flush with EX empty.
        idle(); flush_ex = 1; cycle();
        issue(12, 0, 1); cycle();
        idle(); flush_ex = 1; cycle();
        idle(); id(12, 1, 12, 1);
        settle();
        chk("fl_nostall", {31'd0, stall}, 32'd0);
        chk("fl_pend12", {31'd0, pending[12]}, 32'd0);
        chk("fl_err", {31'd0, err}, 32'd0); adv();

        // x0 is never tracked.
        idle(); issue(0, 1, 1); cycle();
        idle(); id(0, 1, 0, 1); wb(0, 1);
        settle();
        chk("x0_stall", {31'd0, stall}, 32'd0);
        chk("x0_pend", {31'd0, pending[0]}, 32'd0); adv();
        idle(); settle(); chk("x0_err", {31'd0, err}, 32'd0); adv();

        // WB to an idle register is an error, and it is sticky.
        wb(3, 0); cycle();
        idle(); settle(); chk("unf_err", {31'd0, err}, 32'd1); adv();
        cycle();
        settle(); chk("unf_sticky", {31'd0, err}, 32'd1); adv();
        do_reset();

        // Four unretired writers to x4 saturate the counter at 3.
        for (int i = 0; i < 4; i++) begin
            issue(4, 0, 0); cycle();
        end
        idle(); settle();
        chk("sat_err", {31'd0, err}, 32'd1);
        chk("sat_pend4", {31'd0, pending[4]}, 32'd1); adv();
        for (int i = 0; i < 2; i++) begin
            wb(4, 0); cycle();
        end
        idle(); settle(); chk("sat_pend4_two", {31'd0, pending[4]}, 32'd1); adv();
        wb(4, 0); cycle();
        idle(); settle(); chk("sat_pend4_zero", {31'd0, pending[4]}, 32'd0); adv();

        // Asynchronous reset in the middle of a long-op stall.
        issue(9, 0, 1); cycle();
        idle(); id(9, 1, 0, 0);
        settle(); chk("ar_stall_before", {31'd0, stall}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("ar_stall", {31'd0, stall}, 32'd0);
        chk("ar_pending", pending, 32'd0);
        chk("ar_err", {31'd0, err}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();
        idle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-producer tracker and stall generator for the pipeline's issue/decode boundary. It records every in-flight register write from the moment it is issued into EX until it retires in WB. It raises `stall` when a decode-stage source cannot be covered by the EX/MEM forwarding paths: load-use on the load still in EX, or any read of a long-latency result not yet written back. Its stall output and per-register pending state feed the decode/issue controller alongside the forwarding logic.

## Interface
- `NUM_REGS`, 32: architectural registers; x0 is never tracked.
- `CNT_W`, 2: per-register in-flight writer counter width; saturates at 2^CNT_W-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: instruction leaving ID into EX this cycle; ignored while `stall`=1.
- `issue_regwrite` in 1: issued instruction writes `issue_rd`.
- `issue_rd` in 5: destination of issued instruction.
- `issue_is_load` in 1: issued instruction is a load.
- `issue_is_long` in 1: issued instruction is multi-cycle (div/rem); result arrives only via WB.
- `flush_ex` in 1: kill the instruction currently in EX.
- `wb_valid` in 1: register-file write this cycle.
- `wb_rd` in 5: write-back destination.
- `wb_long` in 1: write-back is a long-latency result.
- `id_rs1`, `id_rs2` in 5: decode sources.
- `id_use_rs1`, `id_use_rs2` in 1: source actually read.
- `stall` out 1: hold PC/IF/ID; no issue this cycle.
- `pending` out NUM_REGS: bit r = counter r nonzero.
- `err` out 1: sticky; counter overflow or WB to a register with counter 0.

## Operation
- Effective issue `iss` = `issue_valid && !stall && issue_regwrite && issue_rd!=0`.
- Per-register counter `cnt[r]`: +1 on `iss` to r; -1 on `wb_valid` to r (r!=0); both on the same r → unchanged. Increment at max saturates and sets `err`. Decrement at 0 stays 0 and sets `err`.
- Per-register `long[r]`: set on `iss && issue_is_long` to r; cleared on `wb_valid && wb_long` to r. If set and clear hit the same r together, set wins.
- EX tracker (`ex_valid`, `ex_rd`, `ex_load`, `ex_long`): loaded from every `issue_valid && !stall` each cycle, else cleared. `ex_valid` only if `iss`.
- `flush_ex` with `ex_valid`: decrement `cnt[ex_rd]` and clear `long[ex_rd]` if `ex_long`. The tracker clears next edge. A same-cycle issue still loads normally. `flush_ex` with `ex_valid`=0 has no effect.
- Stall, for each used source s != 0:
  - load-use: `ex_valid && ex_load && ex_rd==s`;
  - long: `long[s]` unless `wb_valid && wb_long && wb_rd==s` this cycle (RF write-through covers it).
  - `stall` = OR of all terms.
- x0: never set, never stalls, WB to x0 ignored (no `err`).

## Timing
- Reset (async assert, sync release): all `cnt`=0, `long`=0, tracker cleared, `stall`=0, `pending`=0, `err`=0. Reset mid-operation discards all in-flight state.
- `stall` is combinational from registered state plus ID/WB inputs in the same cycle. Load-use gives exactly one bubble: the load moves to MEM, the tracker clears, and MEM→ID forwarding takes over.
- `cnt`/`long`/tracker updates are visible the cycle after the triggering edge. `pending` is registered-state derived, with zero extra latency.
- Long op: `stall` holds for every cycle a dependent sits in ID until the WB cycle, which itself does not stall.
- `err` clears only on reset.

## Structure
- Shared package `pipeline_pkg`: `NUM_REGS`, `CNT_W`, `reg_idx_t` (5-bit), `REG_ZERO`.
- Sub-module `scoreboard_entry`: one register's `cnt` + `long` with inc/dec/set/clear/flush inputs and overflow/underflow flags. Instantiate with a generate over r=1..NUM_REGS-1; the top holds the EX tracker, stall mux and `err`.

## Test plan
- Load-use: issue `lw x5` then ID `add x6,x5,x1` → `stall`=1 exactly one cycle; `pending[5]`=1 until WB to x5, then 0.
- Back-to-back writers: issue `addi x7` twice in successive cycles → `cnt[7]`=2; first WB x7 → `pending[7]` stays 1; second WB → 0; no stall at any point.
- Long op: issue `div x9` (`issue_is_long`), dependent `sub x10,x9,x2` in ID → `stall` high until the cycle `wb_valid && wb_long && wb_rd=9`, low that cycle; `long[9]` clear after.
- Flush: issue `div x12`, assert `flush_ex` next cycle → `pending[12]`=0, no stall for readers of x12, `err`=0.
- Boundaries: issue/WB targeting x0 → `pending[0]`=0, no stall. WB to x3 with `cnt[3]`=0 → `err`=1 sticky. Four unretired writers to x4 → saturate at 3, `err`=1.
- Async reset asserted mid-stall (long pending on x9) → `stall`, `pending`, `err` all 0 immediately, without waiting for a clock edge.
